bram_write: RTL and testbench
=============================

BRAM_WRITE -- requirements
Module: bram_write

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, data width; LOG_MAX_ITERS, default 16, iteration counter width; LOG_MAX_WRITES_PER_ITER, default 16, writes-per-iteration counter width; LOG_MAX_ADDRESS, default 16, BRAM address width.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 configure  in  1  CONFIGURE: load pulse.
REQ-005 num_iters  in  LOG_MAX_ITERS  CONFIGURE: iteration count.
REQ-006 num_writes_per_iter  in  LOG_MAX_WRITES_PER_ITER  CONFIGURE: writes per iteration.
REQ-007 base_address  in  LOG_MAX_ADDRESS  CONFIGURE: first BRAM address of each iteration.
REQ-008 avail_out  out  1  IN: this block can accept data from the upstream stream stage.
REQ-009 valid_in  in  1  IN: upstream data valid.
REQ-010 data_in  in  DATA_WIDTH  IN: upstream data.
REQ-011 write_out  out  1  OUT: BRAM write strobe.
REQ-012 address_out  out  LOG_MAX_ADDRESS  OUT: BRAM write address.
REQ-013 data_out  out  DATA_WIDTH  OUT: BRAM write data.
REQ-014 done  out  1  one-cycle pulse after the final write of a configuration.
REQ-015 overflow  out  1  sticky: valid_in arrived while the FIFO was full.

Function
REQ-016 Input data SHALL pass through a 4-slot FIFO; a valid_in with the FIFO not full SHALL be pushed at that edge.
REQ-017 avail_out SHALL be enabled_r & ~almost_full, where almost_full means at most 1 free slot. A word in flight when avail_out falls therefore always fits.
REQ-018 valid_in with the FIFO full SHALL drop the word and set overflow. overflow SHALL clear only on reset or configure.
REQ-019 The FSM SHALL have states IDLE and ACTIVE:
- IDLE -> ACTIVE on configure with num_iters != 0 and num_writes_per_iter != 0.
- ACTIVE -> IDLE on the last write of the last iteration.
REQ-020 write_out SHALL be (state == ACTIVE) & ~empty. When write_out is 1, data_out SHALL be the FIFO head, address_out SHALL be addr_r, and the FIFO SHALL pop in the same cycle.
REQ-021 Latency: valid_in at cycle t into an empty FIFO SHALL produce write_out at cycle t+1.
REQ-022 On each write the counters SHALL update as follows:
- Not the last write of an iteration: writes counter decrements; addr_r increments modulo 2^LOG_MAX_ADDRESS.
- Last write of an iteration that is not the final iteration: iters decrements; writes counter reloads from its copy; addr_r reloads base_address.
- Final write: state -> IDLE; done = 1 in the next cycle.
REQ-023 configure SHALL have priority over all other events:
- loads counters, copies and addr_r;
- flushes the FIFO;
- clears overflow;
- aborts any configuration in progress without a done pulse.
REQ-024 configure with num_iters == 0 or num_writes_per_iter == 0 SHALL leave state IDLE, produce no writes, and pulse done in the next cycle.
REQ-025 Simultaneous push and pop SHALL keep the FIFO occupancy unchanged. A push to an empty FIFO SHALL NOT be written to BRAM in the same cycle.
REQ-026 In IDLE, avail_out SHALL be 0. Words arriving anyway SHALL be stored if there is room and written after the next configure only if the FIFO is not flushed; since configure always flushes, such words are discarded.

Reset
REQ-027 With rst == 0 at a clock edge, the block SHALL set:
- state = IDLE; FIFO empty; counters, copies and addr_r = 0;
- avail_out = 0, write_out = 0, done = 0, overflow = 0;
- address_out = 0, data_out = don't-care.
REQ-028 Reset asserted mid-configuration SHALL abort it with no further writes and no done pulse.

Structure
REQ-029 FSM state encodings (IDLE = 0, ACTIVE = 1) SHALL be shared constants in the common defines file, alongside the existing FSM_* defines.
REQ-030 The block SHALL instantiate the existing FIFO sub-module (NUM_SLOTS = 4, LOG_NUM_SLOTS = 2). No other sub-module is needed.
REQ-031 An optional `DEBUG block SHALL print a cycle counter with configure, write_out (address and data) and overflow events.

Verification
REQ-032 Basic: configure iters = 1, writes = 4, base = 0x10; feed A0..A3 back-to-back -> writes at 0x10..0x13 in cycles t+1..t+4 with data A0..A3; done pulses once.
REQ-033 Multi-iteration: iters = 3, writes = 2, base = 0x20; feed 6 words -> addresses 20, 21, 20, 21, 20, 21; done only after the 6th write.
REQ-034 Backpressure: valid_in held high every cycle while avail_out is honoured -> no overflow; avail_out drops when occupancy reaches 3.
REQ-035 Overflow: force 5 valid_in with no pops (hold in IDLE) -> overflow = 1 and stays set; the next configure clears it.
REQ-036 Zero and abort cases:
- configure with writes = 0 -> no write_out; done in the next cycle.
- Re-configure after 2 of 4 writes -> FIFO flushed, no done, writes restart at the new base.
REQ-037 Reset: rst low mid-run -> all outputs at reset values in the next cycle; no write_out until the next configure.

Source files
------------

// File: rtl/bram_write_pkg.sv
// Shared constants for the BRAM write sequencer: FSM encodings and FIFO geometry.
package bram_write_pkg;

    typedef enum logic {
        FSM_IDLE   = 1'b0,
        FSM_ACTIVE = 1'b1
    } fsm_state_t;

    localparam int FIFO_NUM_SLOTS     = 4;
    localparam int FIFO_LOG_NUM_SLOTS = 2;

endpackage

// File: rtl/bram_write_fifo.sv
// Small circular FIFO with occupancy flags; flush empties it in one cycle.
module bram_write_fifo #(
    parameter int WIDTH         = 8,
    parameter int NUM_SLOTS     = 4,
    parameter int LOG_NUM_SLOTS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             almost_full
);

    localparam logic [LOG_NUM_SLOTS:0] SLOTS = (LOG_NUM_SLOTS + 1)'(NUM_SLOTS);

    logic [WIDTH-1:0]         mem [NUM_SLOTS];
    logic [LOG_NUM_SLOTS-1:0] rd_ptr;
    logic [LOG_NUM_SLOTS-1:0] wr_ptr;
    logic [LOG_NUM_SLOTS:0]   count;
    logic                     do_push;
    logic                     do_pop;

    assign empty       = (count == '0);
    assign full        = (count == SLOTS);
    // At most one free slot left: a word already in flight still fits.
    assign almost_full = (count >= SLOTS - 1'b1);
    assign head        = mem[rd_ptr];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: rtl/bram_write.sv
// Streams FIFO-buffered input words into BRAM over num_iters passes of
// num_writes_per_iter consecutive addresses starting at base_address.
//
//   state  | meaning
//   IDLE   | no configuration running; input not accepted, no writes
//   ACTIVE | writing FIFO words to BRAM until the final write of the last pass
module bram_write
    import bram_write_pkg::*;
#(
    parameter int DATA_WIDTH              = 8,
    parameter int LOG_MAX_ITERS           = 16,
    parameter int LOG_MAX_WRITES_PER_ITER = 16,
    parameter int LOG_MAX_ADDRESS         = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               configure,
    input  logic [LOG_MAX_ITERS-1:0]           num_iters,
    input  logic [LOG_MAX_WRITES_PER_ITER-1:0] num_writes_per_iter,
    input  logic [LOG_MAX_ADDRESS-1:0]         base_address,
    output logic                               avail_out,
    input  logic                               valid_in,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic                               write_out,
    output logic [LOG_MAX_ADDRESS-1:0]         address_out,
    output logic [DATA_WIDTH-1:0]              data_out,
    output logic                               done,
    output logic                               overflow
);

    fsm_state_t                         state;
    logic                               enabled_r;
    logic [LOG_MAX_ITERS-1:0]           iters_r;
    logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_r;
    logic [LOG_MAX_WRITES_PER_ITER-1:0] writes_copy_r;
    logic [LOG_MAX_ADDRESS-1:0]         base_r;
    logic [LOG_MAX_ADDRESS-1:0]         addr_r;
    logic                               done_r;
    logic                               overflow_r;

    logic                               fifo_empty;
    logic                               fifo_full;
    logic                               fifo_almost_full;
    logic [DATA_WIDTH-1:0]              fifo_head;
    logic                               last_of_iter;
    logic                               final_iter;

    bram_write_fifo #(
        .WIDTH         (DATA_WIDTH),
        .NUM_SLOTS     (FIFO_NUM_SLOTS),
        .LOG_NUM_SLOTS (FIFO_LOG_NUM_SLOTS)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (configure),
        .push        (valid_in),
        .pop         (write_out),
        .data_in     (data_in),
        .head        (fifo_head),
        .empty       (fifo_empty),
        .full        (fifo_full),
        .almost_full (fifo_almost_full)
    );

    // A configure in the same cycle aborts the old run, so its pending write is suppressed.
    assign write_out   = (state == FSM_ACTIVE) & ~fifo_empty & ~configure;
    assign avail_out   = enabled_r & ~fifo_almost_full;
    assign address_out = addr_r;
    assign data_out    = fifo_head;
    assign done        = done_r;
    assign overflow    = overflow_r;

    assign last_of_iter = (writes_r == LOG_MAX_WRITES_PER_ITER'(1));
    assign final_iter   = (iters_r == LOG_MAX_ITERS'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= FSM_IDLE;
            enabled_r     <= 1'b0;
            iters_r       <= '0;
            writes_r      <= '0;
            writes_copy_r <= '0;
            base_r        <= '0;
            addr_r        <= '0;
            done_r        <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (configure) begin
                iters_r       <= num_iters;
                writes_r      <= num_writes_per_iter;
                writes_copy_r <= num_writes_per_iter;
                base_r        <= base_address;
                addr_r        <= base_address;
                overflow_r    <= 1'b0;
                if (num_iters != '0 && num_writes_per_iter != '0) begin
                    state     <= FSM_ACTIVE;
                    enabled_r <= 1'b1;
                end else begin
                    state     <= FSM_IDLE;
                    enabled_r <= 1'b0;
                    done_r    <= 1'b1;
                end
            end else begin
                if (valid_in && fifo_full) begin
                    overflow_r <= 1'b1;
                end
                if (write_out) begin
                    if (!last_of_iter) begin
                        writes_r <= writes_r - 1'b1;
                        addr_r   <= addr_r + 1'b1;
                    end else if (!final_iter) begin
                        iters_r  <= iters_r - 1'b1;
                        writes_r <= writes_copy_r;
                        addr_r   <= base_r;
                    end else begin
                        state     <= FSM_IDLE;
                        enabled_r <= 1'b0;
                        done_r    <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef DEBUG
    logic [31:0] dbg_cycle;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dbg_cycle <= '0;
        end else begin
            dbg_cycle <= dbg_cycle + 1'b1;
            if (configure) begin
                $display("[%0d] configure iters=%0d writes=%0d base=%0h",
                         dbg_cycle, num_iters, num_writes_per_iter, base_address);
            end
            if (write_out) begin
                $display("[%0d] write addr=%0h data=%0h", dbg_cycle, address_out, data_out);
            end
            if (valid_in && fifo_full && !configure) begin
                $display("[%0d] overflow, word dropped", dbg_cycle);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bram_write.sv
// Directed bench for bram_write: streaming, multi-pass, backpressure, overflow, abort, reset.
module tb_bram_write;

    logic        clk = 1'b0;
    logic        rst;
    logic        configure;
    logic [15:0] num_iters;
    logic [15:0] num_writes_per_iter;
    logic [15:0] base_address;
    logic        avail_out;
    logic        valid_in;
    logic [7:0]  data_in;
    logic        write_out;
    logic [15:0] address_out;
    logic [7:0]  data_out;
    logic        done;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bram_write dut (
        .clk                 (clk),
        .rst                 (rst),
        .configure           (configure),
        .num_iters           (num_iters),
        .num_writes_per_iter (num_writes_per_iter),
        .base_address        (base_address),
        .avail_out           (avail_out),
        .valid_in            (valid_in),
        .data_in             (data_in),
        .write_out           (write_out),
        .address_out         (address_out),
        .data_out            (data_out),
        .done                (done),
        .overflow            (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_configure(input int iters, input int writes, input int base);
        configure           = 1'b1;
        num_iters           = 16'(iters);
        num_writes_per_iter = 16'(writes);
        base_address        = 16'(base);
        step();
        configure = 1'b0;
    endtask

    // Feeds words A0+i back-to-back; each should be written one cycle after it is offered.
    task automatic stream(input int n, input int wpi, input int base);
        valid_in = 1'b1;
        data_in  = 8'hA0;
        for (int i = 0; i < n; i++) begin
            step();
            check("stream_write", 32'(write_out), 32'd1);
            check("stream_addr", 32'(address_out), 32'(base + (i % wpi)));
            check("stream_data", 32'(data_out), 32'(8'hA0 + i));
            check("stream_no_done", 32'(done), 32'd0);
            check("stream_avail", 32'(avail_out), 32'd1);
            if (i + 1 < n) begin
                data_in = 8'(8'hA0 + i + 1);
            end else begin
                valid_in = 1'b0;
            end
        end
        step();
        check("stream_end_write", 32'(write_out), 32'd0);
        check("stream_done", 32'(done), 32'd1);
        step();
        check("stream_done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int nw;
        int nd;
        rst                 = 1'b0;
        configure           = 1'b0;
        num_iters           = '0;
        num_writes_per_iter = '0;
        base_address        = '0;
        valid_in            = 1'b0;
        data_in             = '0;
        step();
        step();
        check("rst_avail", 32'(avail_out), 32'd0);
        check("rst_write", 32'(write_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_addr", 32'(address_out), 32'd0);
        rst = 1'b1;
        step();

        // basic: one pass of 4 writes at 0x10
        do_configure(1, 4, 16'h10);
        check("basic_avail", 32'(avail_out), 32'd1);
        stream(4, 4, 16'h10);

        // three passes of two writes at 0x20
        do_configure(3, 2, 16'h20);
        stream(6, 2, 16'h20);
        check("multi_idle_avail", 32'(avail_out), 32'd0);

        // backpressure: offer a word whenever avail_out allows
        do_configure(1, 8, 16'h30);
        nw = 0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            valid_in = avail_out;
            data_in  = 8'(i);
            step();
            if (write_out) nw++;
            if (done) nd++;
        end
        valid_in = 1'b0;
        check("bp_overflow", 32'(overflow), 32'd0);
        check("bp_writes", 32'(nw), 32'd8);
        check("bp_done_count", 32'(nd), 32'd1);

        // overflow: five words into an idle FIFO of four slots
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1;
            data_in  = 8'(8'hB0 + i);
            step();
            if (i == 3) check("ovf_at_full", 32'(overflow), 32'd0);
        end
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_idle_avail", 32'(avail_out), 32'd0);
        valid_in = 1'b0;
        step();
        step();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_idle_write", 32'(write_out), 32'd0);
        do_configure(1, 1, 16'h05);
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_flushed", 32'(write_out), 32'd0);
        check("ovf_avail", 32'(avail_out), 32'd1);
        stream(1, 1, 16'h05);

        // zero-length configurations
        do_configure(2, 0, 16'h40);
        check("zero_w_done", 32'(done), 32'd1);
        check("zero_w_write", 32'(write_out), 32'd0);
        check("zero_w_avail", 32'(avail_out), 32'd0);
        step();
        check("zero_w_done_pulse", 32'(done), 32'd0);
        do_configure(0, 3, 16'h40);
        check("zero_i_done", 32'(done), 32'd1);
        check("zero_i_write", 32'(write_out), 32'd0);

        // abort: re-configure after 2 of 4 writes with a word still queued
        do_configure(1, 4, 16'h50);
        valid_in = 1'b1;
        data_in  = 8'hC0;
        step();
        check("abort_w0_addr", 32'(address_out), 32'h50);
        check("abort_w0_data", 32'(data_out), 32'hC0);
        data_in = 8'hC1;
        step();
        check("abort_w1_addr", 32'(address_out), 32'h51);
        check("abort_w1_data", 32'(data_out), 32'hC1);
        data_in = 8'hC2;
        step();
        valid_in = 1'b0;
        do_configure(1, 2, 16'h60);
        check("abort_flushed", 32'(write_out), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_new_base", 32'(address_out), 32'h60);
        stream(2, 2, 16'h60);

        // reset in the middle of a run
        do_configure(1, 4, 16'h70);
        valid_in = 1'b1;
        data_in  = 8'hD0;
        step();
        check("mid_w0_addr", 32'(address_out), 32'h70);
        data_in = 8'hD1;
        step();
        check("mid_w1_addr", 32'(address_out), 32'h71);
        data_in = 8'hD2;
        rst     = 1'b0;
        step();
        check("mid_rst_write", 32'(write_out), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_avail", 32'(avail_out), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_addr", 32'(address_out), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_write", 32'(write_out), 32'd0);
            check("post_rst_done", 32'(done), 32'd0);
        end
        valid_in = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
